// File: rtl/decoder38_strobe.sv
// 3-to-8 strobe decoder: accepts a code/length request, drives a one-hot
// strobe for len+1 cycles, pulses done, then idles for GAP cycles.
module decoder38_strobe #(
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  input  logic [3:0] in_len,
  output logic [7:0] y,
  output logic       busy,
  output logic       done
);

  localparam int unsigned Y_W   = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP != 0) ? CNT_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             done_q, done_d;

  // State register; the down-counter is shared by DRIVE and GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DRIVE;
          cnt_d   = in_len;
          y_d     = Y_W'(1) << in_code;
        end
      end
      S_DRIVE: begin
        if (cnt_q == '0) begin
          y_d    = '0;
          done_d = 1'b1;
          if (GAP != 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        y_d     = '0;
      end
    endcase
  end

  // Handshake and status are pure decodes of the state register
  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign y        = y_q;
  assign done     = done_q;

endmodule

// File: tb/tb_decoder38_strobe.sv
// Bench for decoder38_strobe: one GAP=0 and one GAP=1 instance checked each
// cycle against a timestamp model of the strobe/done/ready timing.
module tb_decoder38_strobe;

  logic       clk;
  logic       rst_n;
  logic       v0, v1;
  logic [2:0] c0, c1;
  logic [3:0] l0, l1;
  logic       rdy0, rdy1, busy0, busy1, done0, done1;
  logic [7:0] y0, y1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state per instance: 0 -> GAP=0, 1 -> GAP=1
  bit m_act   [2];
  int m_start [2];
  int m_len   [2];
  int m_code  [2];
  int gapv    [2];

  decoder38_strobe #(.GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_code(c0),
    .in_len(l0), .y(y0), .busy(busy0), .done(done0)
  );

  decoder38_strobe #(.GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_code(c1),
    .in_len(l1), .y(y1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_ready(int g, int c);
    return !m_act[g] || (c >= m_start[g] + m_len[g] + 1 + gapv[g]);
  endfunction

  function automatic logic [7:0] exp_y(int g, int c);
    if (m_act[g] && c >= m_start[g] && c <= m_start[g] + m_len[g])
      return 8'(1) << m_code[g];
    return 8'h00;
  endfunction

  function automatic bit exp_done(int g, int c);
    return m_act[g] && (c == m_start[g] + m_len[g] + 1);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("g0_y",     y0,    exp_y(0, cyc));
    chk("g0_done",  8'(done0), 8'(exp_done(0, cyc)));
    chk("g0_ready", 8'(rdy0),  8'(exp_ready(0, cyc)));
    chk("g0_busy",  8'(busy0), 8'(!exp_ready(0, cyc)));
    chk("g0_onehot", 8'($countones(y0) <= 1), 8'd1);
    chk("g1_y",     y1,    exp_y(1, cyc));
    chk("g1_done",  8'(done1), 8'(exp_done(1, cyc)));
    chk("g1_ready", 8'(rdy1),  8'(exp_ready(1, cyc)));
    chk("g1_busy",  8'(busy1), 8'(!exp_ready(1, cyc)));
    chk("g1_onehot", 8'($countones(y1) <= 1), 8'd1);
  endtask

  // One clock: model acceptance at the rising edge, check at the falling edge
  task automatic tick();
    int prev;
    @(posedge clk);
    prev = cyc;
    cyc++;
    if (rst_n && v0 && exp_ready(0, prev)) begin
      m_act[0] = 1'b1; m_start[0] = cyc; m_len[0] = int'(l0); m_code[0] = int'(c0);
    end
    if (rst_n && v1 && exp_ready(1, prev)) begin
      m_act[1] = 1'b1; m_start[1] = cyc; m_len[1] = int'(l1); m_code[1] = int'(c1);
    end
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    check_all();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    gapv[0] = 0; gapv[1] = 1;
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    rst_n = 1'b0;
    v0 = 1'b0; c0 = '0; l0 = '0;
    v1 = 1'b0; c1 = '0; l1 = '0;

    // Reset state, held across edges with valid high: nothing accepted
    #2 check_all();
    v0 = 1'b1; v1 = 1'b1;
    tick();
    tick();
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;
    tick();

    // GAP=1, code 5, len 2
    v1 = 1'b1; c1 = 3'd5; l1 = 4'd2;
    tick();
    v1 = 1'b0;
    chk("r26_y_c1", y1, 8'h20);
    tick();
    chk("r26_y_c2", y1, 8'h20);
    tick();
    chk("r26_y_c3", y1, 8'h20);
    chk("r26_rdy_c3", 8'(rdy1), 8'd0);
    tick();
    chk("r26_done", 8'(done1), 8'd1);
    chk("r26_y_off", y1, 8'h00);
    chk("r26_rdy_gap", 8'(rdy1), 8'd0);
    tick();
    chk("r26_rdy_back", 8'(rdy1), 8'd1);
    chk("r26_done_once", 8'(done1), 8'd0);

    // Sweep all codes with len 0 on both instances
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1; c0 = 3'(i); l0 = 4'd0;
      v1 = 1'b1; c1 = 3'(i); l1 = 4'd0;
      tick();
      v0 = 1'b0; v1 = 1'b0;
      chk("r27_sweep_y1", y1, 8'(1) << i);
      tick();
      tick();
    end

    // GAP=0 back-to-back longest strobes with valid held high
    v0 = 1'b1; c0 = 3'd4; l0 = 4'd15;
    for (int i = 0; i < 34; i++) tick();
    v0 = 1'b0;
    for (int i = 0; i < 18; i++) tick();

    // Code changes while busy are ignored until IDLE
    v1 = 1'b1; c1 = 3'd3; l1 = 4'd5;
    tick();
    c1 = 3'd6; l1 = 4'd1;
    tick();
    chk("r29_hold", y1, 8'h08);
    for (int i = 0; i < 10; i++) tick();
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset in DRIVE cycle 2 of a len 7 strobe
    v1 = 1'b1; c1 = 3'd2; l1 = 4'd7;
    tick();
    v1 = 1'b0;
    tick();
    chk("r30_pre", y1, 8'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("r30_async_y", y1, 8'h00);
    chk("r30_async_busy", 8'(busy1), 8'd0);
    m_act[0] = 1'b0; m_act[1] = 1'b0;
    check_all();
    #2 rst_n = 1'b1;
    tick();
    chk("r30_no_done", 8'(done1), 8'd0);
    v1 = 1'b1; c1 = 3'd1; l1 = 4'd0;
    tick();
    v1 = 1'b0;
    chk("r30_restart", y1, 8'h02);
    tick();
    tick();

    // Random traffic with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      v0 = 1'($urandom_range(0, 1)); c0 = 3'($urandom); l0 = 4'($urandom_range(0, 5));
      v1 = 1'($urandom_range(0, 1)); c1 = 3'($urandom); l1 = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 59) == 0) async_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
